// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator and its dead-time stage.
package pwm_pkg;

  localparam int COUNT_W = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 8'hFF;

  typedef logic [COUNT_W-1:0] duty_t;

  typedef enum logic [1:0] {
    DT_IDLE_LO = 2'd0,
    DT_WAIT_HI = 2'd1,
    DT_HI      = 2'd2,
    DT_WAIT_LO = 2'd3
  } dt_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time stage: turns the raw PWM level into non-overlapping high/low-side
// gate drives, each asserted only after raw has been stable for DEAD_CYCLES.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic pwm_out,
  output logic pwm_out_n
);

  localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);

  dt_state_e  state_r;
  dt_state_e  state_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_s;

  // Next-state logic: any raw change during a wait restarts the dead-time timer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      DT_IDLE_LO: begin
        if (raw) begin
          state_s = DT_WAIT_HI;
          cnt_s   = DEAD_LOAD;
        end else begin
          state_s = DT_IDLE_LO;
        end
      end
      DT_WAIT_HI: begin
        if (!raw) begin
          state_s = DT_WAIT_LO;
          cnt_s   = DEAD_LOAD;
        end else if (cnt_r == 4'd0) begin
          state_s = DT_HI;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      DT_HI: begin
        if (!raw) begin
          state_s = DT_WAIT_LO;
          cnt_s   = DEAD_LOAD;
        end else begin
          state_s = DT_HI;
        end
      end
      DT_WAIT_LO: begin
        if (raw) begin
          state_s = DT_WAIT_HI;
          cnt_s   = DEAD_LOAD;
        end else if (cnt_r == 4'd0) begin
          state_s = DT_IDLE_LO;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = DT_IDLE_LO;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, timer and gate outputs; outputs decode the next state so they are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= DT_IDLE_LO;
      cnt_r     <= 4'd0;
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pwm_out   <= en & (state_s == DT_HI);
      pwm_out_n <= en & (state_s == DT_IDLE_LO);
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// PWM generator driven by an external free-running 8-bit counter, with a
// double-buffered duty register. Optional dead-time stage: PWM_DEADTIME_EN.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] count,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  output logic       pwm_out,
  output logic       pwm_out_n,
  output logic       period_start
);

  duty_t duty_active_r;
  duty_t duty_pend_r;
  logic  pend_full_r;
  logic  accept_s;
  logic  boundary_s;
  logic  raw_s;

  assign duty_ready = !pend_full_r;
  assign accept_s   = duty_valid & duty_ready;
  assign boundary_s = (count == COUNT_MAX);
  assign raw_s      = (count < duty_active_r);

  // Duty buffering: a write landing on the boundary cycle bypasses the pending slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_active_r <= 8'h00;
      duty_pend_r   <= 8'h00;
      pend_full_r   <= 1'b0;
    end else if (boundary_s && pend_full_r) begin
      duty_active_r <= duty_pend_r;
      pend_full_r   <= 1'b0;
    end else if (boundary_s && accept_s) begin
      duty_active_r <= duty_in;
      pend_full_r   <= 1'b0;
    end else if (accept_s) begin
      duty_pend_r   <= duty_in;
      pend_full_r   <= 1'b1;
    end else begin
      pend_full_r   <= pend_full_r;
    end
  end

  // Period marker follows the counter reaching zero by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= (count == 8'h00);
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_deadtime (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .raw       (raw_s),
    .pwm_out   (pwm_out),
    .pwm_out_n (pwm_out_n)
  );
`else
  // DEAD_CYCLES has no effect without the dead-time stage.
  logic [3:0] unused_dead_s;
  assign unused_dead_s = 4'(DEAD_CYCLES);

  // Plain complementary outputs, both forced low while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      pwm_out   <= en & raw_s;
      pwm_out_n <= en & ~raw_s;
    end
  end
`endif

endmodule
